shift_reg_universal: RTL
========================

SHIFT_REG_UNIVERSAL -- requirements
Module: shift_reg_universal

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 mode  input  3  operation select, encoded per the shared mode enum (REQ-009).
REQ-005 d  input  WIDTH  parallel load data.
REQ-006 sin  input  1  serial data in, used by the SHL and SHR modes.
REQ-007 q  output  WIDTH  register contents.
REQ-008 sout  output  1  registered copy of the last bit shifted or rotated out.
REQ-008a count  output  $clog2(WIDTH+1)  number of shift-type operations since the last LOAD/CLR/reset, saturating.
REQ-008b done  output  1  high when count == WIDTH.

Function
REQ-009 mode encodings SHALL be: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR; all 8 codes are legal.
REQ-010 HOLD SHALL leave q, sout and count unchanged.
REQ-011 LOAD SHALL set q<=d, sout<=0 and count<=0 at the clock edge.
REQ-012 SHL SHALL set q<={q[WIDTH-2:0],sin} and sout<=q[WIDTH-1].
REQ-013 SHR SHALL set q<={sin,q[WIDTH-1:1]} and sout<=q[0].
REQ-014 ROL SHALL set q<={q[WIDTH-2:0],q[WIDTH-1]} and sout<=q[WIDTH-1].
REQ-015 ROR SHALL set q<={q[0],q[WIDTH-1:1]} and sout<=q[0].
REQ-016 ASR SHALL set q<={q[WIDTH-1],q[WIDTH-1:1]} (sign preserved) and sout<=q[0].
REQ-017 CLR SHALL set q<=0, sout<=0 and count<=0 synchronously.
REQ-018 Each SHL/SHR/ROL/ROR/ASR edge SHALL increment count by 1, saturating at WIDTH with no wrap.
REQ-019 done SHALL be combinational from count (count == WIDTH), with zero added latency.
REQ-020 Latency: q, sout and count SHALL reflect an operation in the cycle after the sampling edge; there is no other pipelining.
REQ-021 mode, d and sin SHALL be sampled only at the rising edge of clk; changes between edges SHALL have no effect.

Reset
REQ-022 While reset=1, q, sout and count SHALL be 0 immediately, independent of clk; done SHALL therefore be 0.
REQ-023 If reset asserts mid-sequence (for example during a ROR run), all state SHALL clear at once, and the first edge after deassertion SHALL act on the then-current mode from the zero state.
REQ-024 Reset SHALL take priority over every mode, including LOAD on the same edge.

Structure
REQ-025 Package shift_reg_pkg SHALL hold the mode_t enum (3-bit) and the function count_w(WIDTH)=$clog2(WIDTH+1).
REQ-026 A sub-module dff_en_r SHALL provide the state register: a WIDTH-parameterised D flip-flop with enable and asynchronous active-high reset, used for q, sout and count.
REQ-027 Next-state selection SHALL be one combinational case on mode feeding dff_en_r; enable = (mode != HOLD).

Verification (WIDTH=8)
REQ-028 Load q=0xA5, then pulse reset between clock edges -> q=0x00, count=0, sout=0 before the next edge.
REQ-029 LOAD d=0xB4, then SHL with sin=1 -> q=0x69, sout=1, count=1.
REQ-030 LOAD 0x81, then ROR for 8 edges -> first edge q=0xC0; after the 8th edge q=0x81, count=8, done=1; a 9th ROR -> count stays 8.
REQ-031 LOAD 0x90, then ASR twice -> q=0xC8, then q=0xE4; sout=0 both times; count=2.
REQ-032 LOAD 0x03, SHR with sin=0 -> q=0x01, sout=1; HOLD 3 cycles -> q=0x01, count=1 unchanged; CLR -> q=0, sout=0, count=0.
REQ-033 LOAD d=0xFF on the same edge that reset is high -> q stays 0x00; the bench SHALL check every mode code at least once against a reference model.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// the count-width helper.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_t;

  function automatic int unsigned count_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_en_r.sv
// Width-parameterised D flip-flop with enable and asynchronous active-high
// reset.
module dff_en_r #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      o_q <= '0;
    else if (i_en)
      o_q <= i_d;
  end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold/load/shift/rotate/arith-shift/clear with a
// saturating count of shift-type operations since the last load or clear.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  mode,
  input  logic [WIDTH-1:0]            d,
  input  logic                        sin,
  output logic [WIDTH-1:0]            q,
  output logic                        sout,
  output logic [count_w(WIDTH)-1:0]   count,
  output logic                        done
);

  localparam int unsigned    CW      = count_w(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  mode_t            w_mode;
  logic             w_en;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] r_q;
  logic [0:0]       r_sout;
  logic [CW-1:0]    r_count;

  assign w_mode    = mode_t'(mode);
  assign w_en      = (w_mode != MODE_HOLD);
  assign w_cnt_inc = (r_count == CNT_MAX) ? r_count : r_count + CW'(1);

  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout[0];
    w_cnt_nxt  = r_count;
    case (w_mode)
      MODE_HOLD: ;
      MODE_LOAD: begin
        w_q_nxt    = d;
        w_sout_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
      MODE_SHL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], sin};
        w_sout_nxt = r_q[WIDTH-1];
        w_cnt_nxt  = w_cnt_inc;
      end
      MODE_SHR: begin
        w_q_nxt    = {sin, r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_cnt_nxt  = w_cnt_inc;
      end
      MODE_ROL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_sout_nxt = r_q[WIDTH-1];
        w_cnt_nxt  = w_cnt_inc;
      end
      MODE_ROR: begin
        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_cnt_nxt  = w_cnt_inc;
      end
      MODE_ASR: begin
        w_q_nxt    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_cnt_nxt  = w_cnt_inc;
      end
      MODE_CLR: begin
        w_q_nxt    = '0;
        w_sout_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
      default: ;
    endcase
  end

  dff_en_r #(.WIDTH(WIDTH)) u_q_reg (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_en),
    .i_d     (w_q_nxt),
    .o_q     (r_q)
  );

  dff_en_r #(.WIDTH(1)) u_sout_reg (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_en),
    .i_d     (w_sout_nxt),
    .o_q     (r_sout)
  );

  dff_en_r #(.WIDTH(CW)) u_cnt_reg (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_en),
    .i_d     (w_cnt_nxt),
    .o_q     (r_count)
  );

  assign q     = r_q;
  assign sout  = r_sout[0];
  assign count = r_count;
  assign done  = (r_count == CNT_MAX);

endmodule
